vfu_response_router: RTL and testbench
======================================

Name: vfu_response_router

Overview:
- Return path of the slot-to-VFU request interface. Each slot issues requests into a VFU; this block collects the VFU's tagged responses and routes each one back to the slot named by its tag.
- The VFU pipeline cannot be stalled, so the block enforces credit-based issue. The request side may fire only while buffer space is guaranteed.
- Responses are held in an in-order FIFO and delivered to per-slot ready/valid ports. Position: between the VFU output and the lane slot write-back logic.

Parameters:
DEPTH, 4, response FIFO entries and maximum outstanding requests (power of two, ≥2)
DATA_W, 32, response data width
TAG_W, 2, slot tag width; NSLOT = 2**TAG_W slots

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset), sampled on clock
io_reqFire  in  1  a slot request was accepted by the VFU this cycle
io_reqReady  out  1  credit available; issue side may fire next request
io_resp_valid  in  1  VFU response valid (no backpressure)
io_resp_bits_data  in  DATA_W  result data
io_resp_bits_vxsat  in  1  saturation flag
io_resp_bits_executeIndex  in  2  execute index echoed from request
io_resp_bits_tag  in  TAG_W  destination slot
io_out_valid  out  NSLOT  one-hot per-slot response valid
io_out_ready  in  NSLOT  per-slot ready
io_out_bits_data  out  DATA_W  head-entry data (shared by all slots)
io_out_bits_vxsat  out  1  head-entry vxsat
io_out_bits_executeIndex  out  2  head-entry executeIndex
io_overflow  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset==0 at a clock edge): wptr=rptr=0, credit count cnt=0, io_overflow=0. Outputs during reset: io_reqReady=1, io_out_valid=0, data/vxsat/executeIndex=0.
- Credits: cnt holds the number of requests fired whose responses are not yet dequeued, range 0..DEPTH. io_reqReady = (cnt < DEPTH), combinational from cnt.
  - cnt +1 on io_reqFire & io_reqReady.
  - cnt −1 on dequeue.
  - Both in the same cycle: unchanged.
  - io_reqFire while !io_reqReady: cnt unchanged, io_overflow set.
- FIFO: pointers are log2(DEPTH)+1 bits with a wrap bit. empty = (wptr==rptr). full = same index with the wrap bit differing.
- Enqueue: when io_resp_valid. The entry stores {data, vxsat, executeIndex, tag} and wptr increments.
  - If full and no dequeue this cycle: the response is dropped, wptr is held, io_overflow is set.
  - If full and a dequeue occurs this cycle: the enqueue is accepted.
- Latency: a response enqueued at edge t appears on the outputs from cycle t+1. There is no combinational resp→out bypass.
- Head output:
  - !empty: io_out_valid = one-hot(head.tag). bits = head fields.
  - empty: io_out_valid = 0, bits = 0.
- Dequeue = !empty & io_out_ready[head.tag]; rptr increments. Readiness of other slots is ignored. Strict in-order delivery, so head-of-line blocking is intended.
- io_out_valid, once asserted, holds with stable bits until dequeue; ready-before-valid is allowed.
- Pointer wrap-around is natural modulo 2·DEPTH. No special case beyond the full/empty rule.
- io_overflow clears only on reset.
- Reset mid-operation discards all queued entries and credits; io_reqReady is 1 in the cycle after reset is released.

Decomposition:
- Shared package (vfu_pkg): a response struct typedef {data, vxsat, executeIndex, tag} plus the TAG_W and DATA_W defaults, reused by the request-side arbiter and the lane.
- Sub-module vfu_resp_fifo holds the storage, pointers, and full/empty logic. The top level adds the credit counter, tag decode, and overflow flag.

Test Plan:
- Reset/idle: hold reset=0 for 2 cycles, then release → io_reqReady=1, io_out_valid=0000, io_overflow=0.
- Single round-trip: fire 1 request, then at t drive resp tag=2, data=0xDEADBEEF with ready=1111 → at t+1 io_out_valid=0100, data=0xDEADBEEF. Dequeue occurs; cnt returns to 0.
- Credit exhaustion: fire 4 requests with no responses → io_reqReady=0 after the 4th. A 5th fire sets io_overflow=1 and cnt stays 4.
- Head-of-line blocking: enqueue tags 1 then 3 with io_out_ready=1000 → io_out_valid=0010 held for 5 cycles with no dequeue. Setting ready=0010 delivers tag 1; tag 3 is delivered the next cycle.
- Full with simultaneous dequeue: FIFO full (4 entries), head ready, resp_valid same cycle → new entry accepted, count stays 4, io_overflow=0. Repeat with head not ready → response dropped, io_overflow=1.
- Wrap-around: stream 10 responses with tags 0,1,2,3,… and all ready=1 → delivered in order with matching data, pointers wrap twice, no spurious valid.

Source files
------------

// File: rtl/vfu_pkg.sv
// rtl/vfu_pkg.sv - shared VFU response types and width defaults
package vfu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 2;
    localparam int EXEC_W     = 2;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  vxsat;
        logic [EXEC_W-1:0]     execute_index;
        logic [TAG_W_DEF-1:0]  tag;
    } vfu_resp_t;

endpackage

// File: rtl/vfu_resp_fifo.sv
// rtl/vfu_resp_fifo.sv - in-order response storage with wrap-bit pointers
module vfu_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_push;
    logic         w_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop     = i_rd_en & ~o_empty;
    // A full queue still takes a response when the head leaves in the same cycle.
    assign w_push    = i_wr_en & (~o_full | w_pop);
    assign o_drop    = i_wr_en & o_full & ~w_pop;
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];

    // Pointer update; wrap bit distinguishes full from empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents are meaningless while empty so no reset needed.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/vfu_response_router.sv
// rtl/vfu_response_router.sv - credit-gated VFU response return path to per-slot ports
module vfu_response_router
    import vfu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_reqFire,
    output logic                  io_reqReady,
    input  logic                  io_resp_valid,
    input  logic [DATA_W-1:0]     io_resp_bits_data,
    input  logic                  io_resp_bits_vxsat,
    input  logic [EXEC_W-1:0]     io_resp_bits_executeIndex,
    input  logic [TAG_W-1:0]      io_resp_bits_tag,
    output logic [(2**TAG_W)-1:0] io_out_valid,
    input  logic [(2**TAG_W)-1:0] io_out_ready,
    output logic [DATA_W-1:0]     io_out_bits_data,
    output logic                  io_out_bits_vxsat,
    output logic [EXEC_W-1:0]     io_out_bits_executeIndex,
    output logic                  io_overflow
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = DATA_W + 1 + EXEC_W + TAG_W;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_overflow;
    logic [ENT_W-1:0]  w_head;
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_vxsat;
    logic [EXEC_W-1:0] w_head_exec;
    logic [TAG_W-1:0]  w_head_tag;
    logic              w_empty;
    logic              w_full;
    logic              w_drop;
    logic              w_deq;
    logic              w_show;
    logic              w_credit_ok;
    logic              w_inc;
    logic              w_dec;

    vfu_resp_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (io_resp_valid),
        .i_wr_data ({io_resp_bits_data, io_resp_bits_vxsat,
                     io_resp_bits_executeIndex, io_resp_bits_tag}),
        .i_rd_en   (w_deq),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_drop    (w_drop)
    );

    assign {w_head_data, w_head_vxsat, w_head_exec, w_head_tag} = w_head;

    // Only the addressed slot's ready matters: strict in-order delivery.
    assign w_deq       = ~w_empty & io_out_ready[w_head_tag];
    assign w_credit_ok = (r_cnt < CNT_W'(DEPTH));
    assign w_inc       = io_reqFire & w_credit_ok;
    assign w_dec       = w_deq & (r_cnt != '0);
    assign w_show      = reset & ~w_empty;

    assign io_reqReady              = ~reset | w_credit_ok;
    assign io_out_bits_data         = w_show ? w_head_data  : '0;
    assign io_out_bits_vxsat        = w_show ? w_head_vxsat : 1'b0;
    assign io_out_bits_executeIndex = w_show ? w_head_exec  : '0;
    assign io_overflow              = r_overflow;

    // Decode head tag into the one-hot per-slot valid.
    always_comb begin
        io_out_valid = '0;
        if (w_show) io_out_valid[w_head_tag] = 1'b1;
    end

    // Outstanding-request credit counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky protocol error: fire without credit, or response lost to a full queue.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if ((io_reqFire & ~w_credit_ok) | w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    logic w_unused;
    assign w_unused = w_full;

endmodule

// File: tb/tb_vfu_response_router.sv
// tb/tb_vfu_response_router.sv - self-checking bench for vfu_response_router
module tb_vfu_response_router;
    import vfu_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_fire = 1'b0;
    logic        req_ready;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_vxsat = 1'b0;
    logic [1:0]  resp_ei = '0;
    logic [1:0]  resp_tag = '0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;
    logic [31:0] out_data;
    logic        out_vxsat;
    logic [1:0]  out_ei;
    logic        overflow;

    always #5 clock = ~clock;

    vfu_response_router #(.DEPTH(DEPTH), .DATA_W(32), .TAG_W(2)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_reqFire               (req_fire),
        .io_reqReady              (req_ready),
        .io_resp_valid            (resp_valid),
        .io_resp_bits_data        (resp_data),
        .io_resp_bits_vxsat       (resp_vxsat),
        .io_resp_bits_executeIndex(resp_ei),
        .io_resp_bits_tag         (resp_tag),
        .io_out_valid             (out_valid),
        .io_out_ready             (out_ready),
        .io_out_bits_data         (out_data),
        .io_out_bits_vxsat        (out_vxsat),
        .io_out_bits_executeIndex (out_ei),
        .io_overflow              (overflow)
    );

    vfu_resp_t mq[$];
    int        m_cnt = 0;
    bit        m_ovf = 1'b0;
    int        n_cmp = 0;
    int        n_bad = 0;
    int        dut_deliv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock: step the reference model, then compare every output.
    task automatic tick();
        vfu_resp_t e;
        bit        deq;
        bit        full;
        bit        credit_ok;
        if (reset && ((out_valid & out_ready) != 4'b0)) dut_deliv++;
        if (!reset) begin
            mq.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            deq       = (mq.size() > 0) && out_ready[mq[0].tag];
            full      = (mq.size() == DEPTH);
            credit_ok = (m_cnt < DEPTH);
            if (req_fire && !credit_ok) m_ovf = 1'b1;
            if (req_fire && credit_ok) m_cnt++;
            if (deq) begin
                m_cnt--;
                e = mq.pop_front();
            end
            if (resp_valid) begin
                if (full && !deq) begin
                    m_ovf = 1'b1;
                end else begin
                    e.data = resp_data;
                    e.vxsat = resp_vxsat;
                    e.execute_index = resp_ei;
                    e.tag = resp_tag;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        if (!reset || mq.size() == 0) begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, (!reset) ? 1'b1 : (m_cnt < DEPTH)});
            chk("out_valid", {28'b0, out_valid}, 32'h0);
            chk("out_data", out_data, 32'h0);
            chk("out_side", {29'b0, out_vxsat, out_ei}, 32'h0);
        end else begin
            chk("req_ready", {31'b0, req_ready}, {31'b0, (m_cnt < DEPTH)});
            chk("out_valid", {28'b0, out_valid}, 32'(4'b0001 << mq[0].tag));
            chk("out_data", out_data, mq[0].data);
            chk("out_side", {29'b0, out_vxsat, out_ei}, {29'b0, mq[0].vxsat, mq[0].execute_index});
        end
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    endtask

    task automatic drive(input bit fire, input bit rv, input logic [1:0] tag,
                         input logic [31:0] data, input logic [3:0] rdy);
        req_fire   = fire;
        resp_valid = rv;
        resp_tag   = tag;
        resp_data  = data;
        resp_vxsat = data[0];
        resp_ei    = data[5:4];
        out_ready  = rdy;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 2'd0, 32'h0, 4'b0000);
        drive(0, 0, 2'd0, 32'h0, 4'b0000);
        reset = 1'b1;
    endtask

    initial begin
        // Reset / idle
        do_reset();
        drive(0, 0, 2'd0, 32'h0, 4'b0000);
        chk("idle_ready", {31'b0, req_ready}, 32'h1);
        chk("idle_valid", {28'b0, out_valid}, 32'h0);
        chk("idle_ovf", {31'b0, overflow}, 32'h0);

        // Single round trip
        drive(1, 0, 2'd0, 32'h0, 4'b0000);
        drive(0, 1, 2'd2, 32'hDEADBEEF, 4'b1111);
        chk("rt_valid", {28'b0, out_valid}, 32'h4);
        chk("rt_data", out_data, 32'hDEADBEEF);
        drive(0, 0, 2'd0, 32'h0, 4'b1111);
        chk("rt_empty", {28'b0, out_valid}, 32'h0);
        chk("rt_ready", {31'b0, req_ready}, 32'h1);

        // Credit exhaustion
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 2'd0, 32'h0, 4'b0000);
        chk("cr_ready0", {31'b0, req_ready}, 32'h0);
        drive(1, 0, 2'd0, 32'h0, 4'b0000);
        chk("cr_ovf", {31'b0, overflow}, 32'h1);
        drive(0, 1, 2'd0, 32'h1234, 4'b0000);
        drive(0, 0, 2'd0, 32'h0, 4'b0001);
        chk("cr_ready1", {31'b0, req_ready}, 32'h1);

        // Head-of-line blocking
        do_reset();
        drive(1, 0, 2'd0, 32'h0, 4'b1000);
        drive(1, 1, 2'd1, 32'h11, 4'b1000);
        drive(0, 1, 2'd3, 32'h33, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            chk("hol_hold", {28'b0, out_valid}, 32'h2);
            chk("hol_data", out_data, 32'h11);
            drive(0, 0, 2'd0, 32'h0, 4'b1000);
        end
        drive(0, 0, 2'd0, 32'h0, 4'b0010);
        chk("hol_next", {28'b0, out_valid}, 32'h8);
        chk("hol_data3", out_data, 32'h33);
        drive(0, 0, 2'd0, 32'h0, 4'b1000);
        chk("hol_done", {28'b0, out_valid}, 32'h0);

        // Full with and without simultaneous dequeue
        do_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 2'd0, 32'h0, 4'b0000);
        for (int i = 0; i < 4; i++) drive(0, 1, 2'd0, 32'h100 + i, 4'b0000);
        drive(0, 1, 2'd1, 32'hA5, 4'b0001);
        chk("full_acc_ovf", {31'b0, overflow}, 32'h0);
        chk("full_acc_head", out_data, 32'h101);
        drive(0, 1, 2'd2, 32'hBAD, 4'b0000);
        chk("full_drop_ovf", {31'b0, overflow}, 32'h1);
        drive(1, 0, 2'd0, 32'h0, 4'b0000);
        for (int i = 0; i < 5; i++) drive(0, 0, 2'd0, 32'h0, 4'b1111);
        chk("full_drained", {28'b0, out_valid}, 32'h0);

        // Wrap-around stream
        do_reset();
        dut_deliv = 0;
        for (int i = 0; i <= 10; i++)
            drive(i < 10, i > 0, 2'(i - 1), 32'h01010101 * (i + 3), 4'b1111);
        drive(0, 0, 2'd0, 32'h0, 4'b1111);
        drive(0, 0, 2'd0, 32'h0, 4'b1111);
        chk("wrap_count", dut_deliv, 32'd10);

        // Reset mid-operation
        do_reset();
        drive(1, 0, 2'd0, 32'h0, 4'b0000);
        drive(1, 1, 2'd3, 32'h77, 4'b0000);
        drive(0, 1, 2'd0, 32'h88, 4'b0000);
        reset = 1'b0;
        drive(0, 0, 2'd0, 32'h0, 4'b0000);
        chk("rst_valid", {28'b0, out_valid}, 32'h0);
        reset = 1'b1;
        drive(0, 0, 2'd0, 32'h0, 4'b1111);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_empty", {28'b0, out_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
